reg_file_mp: RTL and testbench

//  Multi-ported architectural register file plus rename-status table for the out-of-order core.

---
 rtl/reg_file_mp.sv | 128 ++++++++++++
 tb/tb_reg_file_mp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-ported architectural register file with rename-status table.
// Combinational operand read with intra-bundle and commit bypass; rename/commit/flush update on clk.
module reg_file_mp #(
    parameter int REG_NUM  = 32,
    parameter int XLEN     = 32,
    parameter int ROB_ID_W = 4,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2,
    localparam int RID_W   = $clog2(REG_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           flush,
    input  logic [ISSUE_W-1:0]             iss_valid,
    input  logic [ISSUE_W*RID_W-1:0]       iss_rs,
    input  logic [ISSUE_W*RID_W-1:0]       iss_rt,
    input  logic [ISSUE_W*RID_W-1:0]       iss_rd,
    input  logic [ISSUE_W*ROB_ID_W-1:0]    iss_dest,
    output logic [ISSUE_W*XLEN-1:0]        iss_vj,
    output logic [ISSUE_W*XLEN-1:0]        iss_vk,
    output logic [ISSUE_W*ROB_ID_W-1:0]    iss_qj,
    output logic [ISSUE_W*ROB_ID_W-1:0]    iss_qk,
    input  logic [COMMIT_W-1:0]            cmt_valid,
    input  logic [COMMIT_W*RID_W-1:0]      cmt_rd,
    input  logic [COMMIT_W*ROB_ID_W-1:0]   cmt_dest,
    input  logic [COMMIT_W*XLEN-1:0]       cmt_value
);

    logic [XLEN-1:0]     values [REG_NUM];
    logic [ROB_ID_W-1:0] status [REG_NUM];

    // Operand read; later loop iterations overwrite earlier hits so the youngest producer wins.
    always_comb begin
        logic [RID_W-1:0]    r;
        logic                hit_iss;
        logic                hit_cmt;
        logic [ROB_ID_W-1:0] iss_tag;
        logic [XLEN-1:0]     cmt_val;
        logic [ROB_ID_W-1:0] q;
        logic [XLEN-1:0]     v;

        iss_vj  = '0;
        iss_vk  = '0;
        iss_qj  = '0;
        iss_qk  = '0;
        r       = '0;
        hit_iss = 1'b0;
        hit_cmt = 1'b0;
        iss_tag = '0;
        cmt_val = '0;
        q       = '0;
        v       = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int op = 0; op < 2; op++) begin
                r       = (op == 0) ? iss_rs[i*RID_W +: RID_W] : iss_rt[i*RID_W +: RID_W];
                hit_iss = 1'b0;
                hit_cmt = 1'b0;
                iss_tag = '0;
                cmt_val = '0;
                q       = '0;
                v       = '0;
                for (int j = 0; j < ISSUE_W; j++) begin
                    if (j < i && iss_valid[j] && iss_rd[j*RID_W +: RID_W] == r) begin
                        hit_iss = 1'b1;
                        iss_tag = iss_dest[j*ROB_ID_W +: ROB_ID_W];
                    end
                end
                for (int c = 0; c < COMMIT_W; c++) begin
                    if (cmt_valid[c] && cmt_rd[c*RID_W +: RID_W] == r &&
                        status[r] == cmt_dest[c*ROB_ID_W +: ROB_ID_W]) begin
                        hit_cmt = 1'b1;
                        cmt_val = cmt_value[c*XLEN +: XLEN];
                    end
                end
                if (r == '0) begin
                    q = '0;
                    v = '0;
                end else if (hit_iss) begin
                    q = iss_tag;
                end else if (hit_cmt) begin
                    v = cmt_val;
                end else if (status[r] != '0) begin
                    q = status[r];
                end else begin
                    v = values[r];
                end
                if (op == 0) begin
                    iss_qj[i*ROB_ID_W +: ROB_ID_W] = q;
                    iss_vj[i*XLEN +: XLEN]         = v;
                end else begin
                    iss_qk[i*ROB_ID_W +: ROB_ID_W] = q;
                    iss_vk[i*XLEN +: XLEN]         = v;
                end
            end
        end
    end

    // Renames are applied after commit clears, so a same-cycle rename overrides the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < REG_NUM; k++) begin
                values[k] <= '0;
                status[k] <= '0;
            end
        end else if (rdy) begin
            for (int c = 0; c < COMMIT_W; c++) begin
                if (cmt_valid[c] && cmt_rd[c*RID_W +: RID_W] != '0)
                    values[cmt_rd[c*RID_W +: RID_W]] <= cmt_value[c*XLEN +: XLEN];
            end
            if (flush) begin
                for (int k = 0; k < REG_NUM; k++)
                    status[k] <= '0;
            end else begin
                for (int c = 0; c < COMMIT_W; c++) begin
                    if (cmt_valid[c] && cmt_rd[c*RID_W +: RID_W] != '0 &&
                        status[cmt_rd[c*RID_W +: RID_W]] == cmt_dest[c*ROB_ID_W +: ROB_ID_W])
                        status[cmt_rd[c*RID_W +: RID_W]] <= '0;
                end
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (iss_valid[i] && iss_rd[i*RID_W +: RID_W] != '0)
                        status[iss_rd[i*RID_W +: RID_W]] <= iss_dest[i*ROB_ID_W +: ROB_ID_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: rename, bypass, race, flush, rdy gating and reset.
module tb_reg_file_mp;
    localparam int RID_W = 5;
    localparam int ROB_ID_W = 4;
    localparam int XLEN = 32;
    localparam int ISSUE_W = 2;
    localparam int COMMIT_W = 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         rdy;
    logic                         flush;
    logic [ISSUE_W-1:0]           iss_valid;
    logic [ISSUE_W*RID_W-1:0]     iss_rs, iss_rt, iss_rd;
    logic [ISSUE_W*ROB_ID_W-1:0]  iss_dest;
    logic [ISSUE_W*XLEN-1:0]      iss_vj, iss_vk;
    logic [ISSUE_W*ROB_ID_W-1:0]  iss_qj, iss_qk;
    logic [COMMIT_W-1:0]          cmt_valid;
    logic [COMMIT_W*RID_W-1:0]    cmt_rd;
    logic [COMMIT_W*ROB_ID_W-1:0] cmt_dest;
    logic [COMMIT_W*XLEN-1:0]     cmt_value;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
        .iss_dest(iss_dest), .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj), .iss_qk(iss_qk),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_dest(cmt_dest), .cmt_value(cmt_value)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rdy = 1'b1; flush = 1'b0;
        iss_valid = '0; iss_rs = '0; iss_rt = '0; iss_rd = '0; iss_dest = '0;
        cmt_valid = '0; cmt_rd = '0; cmt_dest = '0; cmt_value = '0;
    endtask

    task automatic set_iss(input int s, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [3:0] dest);
        iss_valid[s] = v;
        iss_rs[s*RID_W +: RID_W] = rs;
        iss_rt[s*RID_W +: RID_W] = rt;
        iss_rd[s*RID_W +: RID_W] = rd;
        iss_dest[s*ROB_ID_W +: ROB_ID_W] = dest;
    endtask

    task automatic set_cmt(input int c, input logic [4:0] rd, input logic [3:0] dest,
                           input logic [31:0] val);
        cmt_valid[c] = 1'b1;
        cmt_rd[c*RID_W +: RID_W] = rd;
        cmt_dest[c*ROB_ID_W +: ROB_ID_W] = dest;
        cmt_value[c*XLEN +: XLEN] = val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks q and v of slot s, operand op (0 = rs/j, 1 = rt/k) after inputs settle.
    task automatic chk_op(input string tag, input int s, input int op,
                          input logic [3:0] eq, input logic [31:0] ev);
        #1;
        if (op == 0) begin
            check({tag, "_qj"}, 32'(iss_qj[s*ROB_ID_W +: ROB_ID_W]), 32'(eq));
            check({tag, "_vj"}, iss_vj[s*XLEN +: XLEN], ev);
        end else begin
            check({tag, "_qk"}, 32'(iss_qk[s*ROB_ID_W +: ROB_ID_W]), 32'(eq));
            check({tag, "_vk"}, iss_vk[s*XLEN +: XLEN], ev);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #12;
        set_iss(0, 1'b0, 5'd5, 5'd0, 5'd0, 4'd0);
        chk_op("rst_init", 0, 0, 4'd0, 32'd0);
        rst = 1'b1;
        step();

        // T2 rename then same-cycle commit bypass
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd5, 4'd3);
        step();
        set_iss(0, 1'b1, 5'd5, 5'd0, 5'd0, 4'd1);
        chk_op("t2_pending", 0, 0, 4'd3, 32'd0);
        set_cmt(0, 5'd5, 4'd3, 32'hABCD);
        chk_op("t2_bypass", 0, 0, 4'd0, 32'hABCD);
        step();
        set_iss(1, 1'b1, 5'd0, 5'd5, 5'd0, 4'd1);
        chk_op("t2_retired", 1, 1, 4'd0, 32'hABCD);

        // T3 intra-bundle RAW; slot0 sees old status of r7
        step();
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd7, 4'd1);
        step();
        set_iss(0, 1'b1, 5'd7, 5'd0, 5'd7, 4'd2);
        set_iss(1, 1'b1, 5'd7, 5'd7, 5'd0, 4'd4);
        chk_op("t3_s0_old", 0, 0, 4'd1, 32'd0);
        chk_op("t3_s1_j", 1, 0, 4'd2, 32'd0);
        chk_op("t3_s1_k", 1, 1, 4'd2, 32'd0);
        step();
        set_iss(0, 1'b0, 5'd7, 5'd0, 5'd0, 4'd0);
        chk_op("t3_after", 0, 0, 4'd2, 32'd0);

        // invalid slot0 must not forward to slot1
        set_iss(0, 1'b0, 5'd0, 5'd0, 5'd5, 4'd9);
        set_iss(1, 1'b1, 5'd5, 5'd0, 5'd0, 4'd4);
        chk_op("inv_slot", 1, 0, 4'd0, 32'hABCD);

        // T4 rename-vs-commit race on r4; rule 2 beats rule 3 for slot1
        step();
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd4, 4'd6);
        step();
        set_cmt(0, 5'd4, 4'd6, 32'h44);
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd4, 4'd9);
        set_iss(1, 1'b1, 5'd4, 5'd0, 5'd0, 4'd10);
        chk_op("t4_iss_over_cmt", 1, 0, 4'd9, 32'd0);
        step();
        chk_op("t4_status9", 0, 0, 4'd0, 32'd0);
        set_iss(0, 1'b0, 5'd4, 5'd0, 5'd0, 4'd0);
        chk_op("t4_status9", 0, 0, 4'd9, 32'd0);

        // two commits to r6 without matching status: no bypass, highest slot value lands
        step();
        set_cmt(0, 5'd6, 4'd11, 32'h60);
        set_cmt(1, 5'd6, 4'd12, 32'h61);
        set_iss(0, 1'b0, 5'd6, 5'd0, 5'd0, 4'd0);
        chk_op("nobyp_r6", 0, 0, 4'd0, 32'd0);
        step();
        set_iss(0, 1'b0, 5'd6, 5'd0, 5'd0, 4'd0);
        chk_op("wr_hi_c", 0, 0, 4'd0, 32'h61);

        // two renames of r8 in one bundle: slot1 wins
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd8, 4'd5);
        set_iss(1, 1'b1, 5'd0, 5'd0, 5'd8, 4'd7);
        step();
        set_iss(0, 1'b0, 5'd8, 5'd0, 5'd0, 4'd0);
        chk_op("ren_hi_i", 0, 0, 4'd7, 32'd0);

        // T5 flush
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd1, 4'd10);
        set_iss(1, 1'b1, 5'd0, 5'd0, 5'd2, 4'd11);
        step();
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd3, 4'd12);
        step();
        flush = 1'b1;
        set_cmt(0, 5'd2, 4'd11, 32'h11);
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd3, 4'd5);
        set_iss(1, 1'b1, 5'd3, 5'd1, 5'd0, 4'd13);
        chk_op("t5_fl_raw", 1, 0, 4'd5, 32'd0);
        chk_op("t5_fl_stat", 1, 1, 4'd10, 32'd0);
        step();
        set_iss(0, 1'b0, 5'd3, 5'd2, 5'd0, 4'd0);
        set_iss(1, 1'b0, 5'd1, 5'd4, 5'd0, 4'd0);
        chk_op("t5_r3", 0, 0, 4'd0, 32'd0);
        chk_op("t5_r2", 0, 1, 4'd0, 32'h11);
        chk_op("t5_r1", 1, 0, 4'd0, 32'd0);
        chk_op("t5_r4", 1, 1, 4'd0, 32'h44);
        set_iss(0, 1'b0, 5'd8, 5'd7, 5'd0, 4'd0);
        chk_op("t5_r8", 0, 0, 4'd0, 32'd0);
        chk_op("t5_r7", 0, 1, 4'd0, 32'd0);

        // T6 rdy=0 holds state; x0 never renamed or written
        step();
        rdy = 1'b0;
        set_cmt(0, 5'd9, 4'd1, 32'h99);
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd10, 4'd4);
        step();
        set_iss(0, 1'b0, 5'd9, 5'd10, 5'd0, 4'd0);
        chk_op("t6_r9", 0, 0, 4'd0, 32'd0);
        chk_op("t6_r10", 0, 1, 4'd0, 32'd0);
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd0, 4'd4);
        set_cmt(0, 5'd0, 4'd2, 32'h77);
        step();
        set_iss(0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0);
        set_iss(1, 1'b1, 5'd0, 5'd0, 5'd0, 4'd0);
        chk_op("t6_x0", 0, 0, 4'd0, 32'd0);

        // T1 mid-run async reset with status[5]=3
        set_iss(0, 1'b1, 5'd0, 5'd0, 5'd5, 4'd3);
        step();
        set_iss(0, 1'b0, 5'd5, 5'd6, 5'd0, 4'd0);
        chk_op("t1_pre", 0, 0, 4'd3, 32'd0);
        rst = 1'b0;
        chk_op("t1_r5", 0, 0, 4'd0, 32'd0);
        chk_op("t1_r6", 0, 1, 4'd0, 32'd0);
        #2;
        rst = 1'b1;
        step();
        set_iss(0, 1'b0, 5'd5, 5'd2, 5'd0, 4'd0);
        chk_op("t1_post_r5", 0, 0, 4'd0, 32'd0);
        chk_op("t1_post_r2", 0, 1, 4'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
